// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake plus the transmitter start/done link shared by
// the arbiter (slave) and whoever drives the requesters and the UART (master).
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]        reqValid;
  logic [NUM_REQ-1:0][7:0]   reqData;
  logic [NUM_REQ-1:0]        reqLast;
  logic [NUM_REQ-1:0]        reqReady;
  logic                      txStart;
  logic [7:0]                txByte;
  logic                      txDone;

  modport master (
    output reqValid, reqData, reqLast, txDone,
    input  reqReady, txStart, txByte
  );

  modport slave (
    input  reqValid, reqData, reqLast, txDone,
    output reqReady, txStart, txByte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources,
// with burst locking, a post-txDone guard gap and a txDone watchdog.
module uart_tx_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int GAP_CYCLES     = 4,
  parameter  int TIMEOUT_CYCLES = 2048,
  localparam int IDW            = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rstN,
  uart_tx_arbiter_if.slave      bus,
  input  logic                  errClr,
  output logic [IDW-1:0]        grantId,
  output logic                  busy,
  output logic                  timeoutErr
);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] ptr, lockId, winner, nextPtr;
  logic           lock, anyElig;
  logic [15:0]    wdCnt;
  logic [GW-1:0]  gapCnt;

  function automatic logic [IDW-1:0] rrIdx(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Lowest rotated distance from ptr wins; a live lock overrides the rotation.
  always_comb begin
    anyElig = 1'b0;
    winner  = '0;
    if (lock && bus.reqValid[lockId]) begin
      anyElig = 1'b1;
      winner  = lockId;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (bus.reqValid[rrIdx(ptr, k)]) begin
          anyElig = 1'b1;
          winner  = rrIdx(ptr, k);
        end
      end
    end
  end

  assign nextPtr = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      bus.txStart  <= 1'b0;
      bus.reqReady <= '0;
      bus.txByte   <= '0;
      grantId      <= '0;
      ptr          <= '0;
      lockId       <= '0;
      lock         <= 1'b0;
      wdCnt        <= '0;
      gapCnt       <= '0;
      busy         <= 1'b0;
      timeoutErr   <= 1'b0;
    end else begin
      bus.txStart  <= 1'b0;
      bus.reqReady <= '0;
      // A watchdog set later in this block overrides the clear.
      if (errClr) timeoutErr <= 1'b0;
      case (state)
        IDLE: begin
          if (lock && !bus.reqValid[lockId]) lock <= 1'b0;
          if (anyElig) begin
            state        <= START;
            bus.txStart  <= 1'b1;
            bus.reqReady <= NUM_REQ'(1) << winner;
            bus.txByte   <= bus.reqData[winner];
            grantId      <= winner;
            ptr          <= nextPtr;
            lock         <= ~bus.reqLast[winner];
            lockId       <= winner;
            busy         <= 1'b1;
          end
        end
        START: begin
          state <= WAIT;
          wdCnt <= '0;
        end
        WAIT: begin
          wdCnt <= wdCnt + 16'd1;
          if (bus.txDone) begin
            state  <= GAP;
            gapCnt <= '0;
          end else if (wdCnt == 16'(TIMEOUT_CYCLES - 1)) begin
            timeoutErr <= 1'b1;
            lock       <= 1'b0;
            state      <= GAP;
            gapCnt     <= '0;
          end
        end
        GAP: begin
          if (gapCnt == GW'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gapCnt <= gapCnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration order, burst lock, gap timing,
// watchdog/errClr priority and async reset, all against hand-computed values.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int G  = 4;
  localparam int T  = 2048;

  logic       clk, rstN, errClr;
  logic [1:0] grantId;
  logic       busy, timeoutErr;
  int         checks = 0;
  int         errors = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rstN(rstN), .bus(bus), .errClr(errClr),
    .grantId(grantId), .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic waitStart(input string nm, output int n);
    n = 0;
    while (bus.txStart !== 1'b1 && n < 60) begin tick(); n++; end
    if (bus.txStart !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_start got no txStart want txStart within 60 cycles", nm);
    end
  endtask

  // From a START negedge: one WAIT cycle, then txDone; returns at first GAP cycle.
  task automatic doneFrame();
    tick(); bus.txDone = 1'b1; tick(); bus.txDone = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (bus.txStart !== 1'b0) begin errors++; $display("FAIL reset_txStart got %b want 0", bus.txStart); end
    checks++; if (bus.reqReady !== 4'b0) begin errors++; $display("FAIL reset_reqReady got %b want 0000", bus.reqReady); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (timeoutErr !== 1'b0) begin errors++; $display("FAIL reset_timeoutErr got %b want 0", timeoutErr); end
    checks++; if (bus.txByte !== 8'h00) begin errors++; $display("FAIL reset_txByte got %h want 00", bus.txByte); end
    checks++; if (grantId !== 2'd0) begin errors++; $display("FAIL reset_grantId got %0d want 0", grantId); end
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int n;
    logic [1:0] exp;
    for (int i = 0; i < NR; i++) bus.reqData[i] = 8'h10 + 8'(i);
    bus.reqLast  = 4'hF;
    bus.reqValid = 4'hF;
    waitStart("rr", n);
    for (int g = 0; g < 6; g++) begin
      exp = 2'(g % 4);
      checks++; if (grantId !== exp) begin errors++; $display("FAIL rr_grantId got %0d want %0d", grantId, exp); end
      checks++; if (bus.txByte !== 8'h10 + 8'(exp)) begin errors++; $display("FAIL rr_txByte got %h want %h", bus.txByte, 8'h10 + 8'(exp)); end
      checks++; if (bus.reqReady !== (4'b1 << exp)) begin errors++; $display("FAIL rr_reqReady got %b want %b", bus.reqReady, 4'b1 << exp); end
      if (g > 0) begin
        checks++; if (n !== G + 1) begin errors++; $display("FAIL rr_gap got %0d want %0d", n, G + 1); end
      end
      if (g == 5) bus.reqValid = '0;
      doneFrame();
      if (g < 5) waitStart("rr", n);
    end
    repeat (G) tick();
  endtask

  task automatic test_single();
    int n;
    bus.reqData[2] = 8'hA5;
    bus.reqLast    = 4'b0100;
    bus.reqValid   = 4'b0100;
    waitStart("single", n);
    checks++; if (n !== 1) begin errors++; $display("FAIL single_latency got %0d want 1", n); end
    checks++; if (bus.reqReady !== 4'b0100) begin errors++; $display("FAIL single_reqReady got %b want 0100", bus.reqReady); end
    checks++; if (bus.txByte !== 8'hA5) begin errors++; $display("FAIL single_txByte got %h want a5", bus.txByte); end
    checks++; if (grantId !== 2'd2) begin errors++; $display("FAIL single_grantId got %0d want 2", grantId); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busyStart got %b want 1", busy); end
    bus.reqValid = '0;
    tick();
    checks++; if (bus.txStart !== 1'b0 || bus.reqReady !== 4'b0) begin errors++; $display("FAIL single_wait got txStart=%b reqReady=%b want 0/0000", bus.txStart, bus.reqReady); end
    bus.txDone = 1'b1; tick(); bus.txDone = 1'b0;
    for (int k = 0; k < G; k++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busyGap%0d got %b want 1", k, busy); end
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busyIdle got %b want 0", busy); end
    checks++; if (bus.txByte !== 8'hA5) begin errors++; $display("FAIL single_txByteHold got %h want a5", bus.txByte); end
  endtask

  task automatic test_burst();
    int n;
    bus.reqData[1] = 8'h11; bus.reqLast = 4'b0000; bus.reqValid = 4'b0010;
    waitStart("burst", n);
    checks++; if (grantId !== 2'd1 || bus.txByte !== 8'h11) begin errors++; $display("FAIL burst_b0 got id=%0d byte=%h want 1/11", grantId, bus.txByte); end
    bus.reqData[0] = 8'hC0; bus.reqData[1] = 8'h22; bus.reqLast = 4'b0001; bus.reqValid = 4'b0011;
    doneFrame(); waitStart("burst", n);
    checks++; if (grantId !== 2'd1 || bus.txByte !== 8'h22) begin errors++; $display("FAIL burst_b1 got id=%0d byte=%h want 1/22", grantId, bus.txByte); end
    bus.reqData[1] = 8'h33; bus.reqLast = 4'b0011;
    doneFrame(); waitStart("burst", n);
    checks++; if (grantId !== 2'd1 || bus.txByte !== 8'h33) begin errors++; $display("FAIL burst_b2 got id=%0d byte=%h want 1/33", grantId, bus.txByte); end
    bus.reqValid = 4'b0001;
    doneFrame(); waitStart("burst", n);
    checks++; if (grantId !== 2'd0 || bus.txByte !== 8'hC0) begin errors++; $display("FAIL burst_other got id=%0d byte=%h want 0/c0", grantId, bus.txByte); end
    bus.reqValid = '0;
    doneFrame(); repeat (G) tick();
  endtask

  task automatic test_lock_release();
    int n;
    bus.reqData[1] = 8'h44; bus.reqLast = 4'b0000; bus.reqValid = 4'b0010;
    waitStart("lockrel", n);
    checks++; if (grantId !== 2'd1 || bus.txByte !== 8'h44) begin errors++; $display("FAIL lockrel_first got id=%0d byte=%h want 1/44", grantId, bus.txByte); end
    bus.reqData[0] = 8'hD0; bus.reqLast = 4'b0001; bus.reqValid = 4'b0001;
    doneFrame(); waitStart("lockrel", n);
    checks++; if (grantId !== 2'd0 || bus.txByte !== 8'hD0) begin errors++; $display("FAIL lockrel_next got id=%0d byte=%h want 0/d0", grantId, bus.txByte); end
    bus.reqValid = '0;
    doneFrame(); repeat (G) tick();
  endtask

  task automatic test_watchdog();
    int n;
    bus.reqData[1] = 8'h5A; bus.reqData[2] = 8'h6B; bus.reqLast = 4'b0100; bus.reqValid = 4'b0110;
    waitStart("wdog", n);
    checks++; if (grantId !== 2'd1) begin errors++; $display("FAIL wdog_grant got %0d want 1", grantId); end
    bus.reqData[1] = 8'h5B;
    for (int k = 1; k <= T + 1; k++) begin
      tick();
      if (k == T) begin
        checks++; if (timeoutErr !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wdog_early got err=%b busy=%b want 0/1", timeoutErr, busy); end
      end
    end
    checks++; if (timeoutErr !== 1'b1) begin errors++; $display("FAIL wdog_set got %b want 1", timeoutErr); end
    waitStart("wdog", n);
    checks++; if (grantId !== 2'd2 || bus.txByte !== 8'h6B) begin errors++; $display("FAIL wdog_next got id=%0d byte=%h want 2/6b", grantId, bus.txByte); end
    bus.reqValid = '0;
    doneFrame(); repeat (G) tick();
    checks++; if (timeoutErr !== 1'b1) begin errors++; $display("FAIL wdog_sticky got %b want 1", timeoutErr); end
    errClr = 1'b1; tick(); errClr = 1'b0;
    checks++; if (timeoutErr !== 1'b0) begin errors++; $display("FAIL wdog_clr got %b want 0", timeoutErr); end
  endtask

  task automatic test_done_timeout();
    int n;
    bus.reqData[0] = 8'hE1; bus.reqLast = 4'b0001; bus.reqValid = 4'b0001;
    waitStart("donetmo", n);
    checks++; if (grantId !== 2'd0) begin errors++; $display("FAIL donetmo_grant got %0d want 0", grantId); end
    bus.reqValid = '0;
    repeat (T) tick();
    bus.txDone = 1'b1; tick(); bus.txDone = 1'b0;
    checks++; if (timeoutErr !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL donetmo_err got err=%b busy=%b want 0/1", timeoutErr, busy); end
    tick(); bus.txDone = 1'b1; tick(); bus.txDone = 1'b0; tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gapdone_busy got %b want 1", busy); end
    tick();
    checks++; if (busy !== 1'b0 || bus.txStart !== 1'b0) begin errors++; $display("FAIL gapdone_idle got busy=%b txStart=%b want 0/0", busy, bus.txStart); end
    bus.txDone = 1'b1; tick(); bus.txDone = 1'b0; tick();
    checks++; if (busy !== 1'b0 || bus.txStart !== 1'b0 || bus.reqReady !== 4'b0) begin errors++; $display("FAIL idledone got busy=%b txStart=%b reqReady=%b want 0/0/0000", busy, bus.txStart, bus.reqReady); end
  endtask

  task automatic test_errclr_coincident();
    int n;
    bus.reqData[3] = 8'h77; bus.reqLast = 4'b1000; bus.reqValid = 4'b1000;
    waitStart("clrset", n);
    checks++; if (grantId !== 2'd3) begin errors++; $display("FAIL clrset_grant got %0d want 3", grantId); end
    bus.reqValid = '0;
    repeat (T) tick();
    errClr = 1'b1; tick(); errClr = 1'b0;
    checks++; if (timeoutErr !== 1'b1) begin errors++; $display("FAIL clrset_err got %b want 1", timeoutErr); end
    repeat (G) tick();
  endtask

  task automatic test_async_reset();
    int n;
    bus.reqData[2] = 8'h99; bus.reqLast = 4'b0000; bus.reqValid = 4'b0100;
    waitStart("arst", n);
    checks++; if (grantId !== 2'd2 || bus.txByte !== 8'h99) begin errors++; $display("FAIL arst_grant got id=%0d byte=%h want 2/99", grantId, bus.txByte); end
    bus.reqData[1] = 8'h81; bus.reqLast = 4'b0010; bus.reqValid = 4'b0110;
    tick(); tick();
    #2 rstN = 1'b0;
    #1;
    checks++; if (bus.txStart !== 1'b0 || bus.reqReady !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL arst_ctl got txStart=%b reqReady=%b busy=%b want 0/0000/0", bus.txStart, bus.reqReady, busy); end
    checks++; if (timeoutErr !== 1'b0 || bus.txByte !== 8'h00 || grantId !== 2'd0) begin errors++; $display("FAIL arst_data got err=%b byte=%h id=%0d want 0/00/0", timeoutErr, bus.txByte, grantId); end
    tick();
    rstN = 1'b1;
    waitStart("arst", n);
    checks++; if (grantId !== 2'd1 || bus.txByte !== 8'h81) begin errors++; $display("FAIL arst_regrant got id=%0d byte=%h want 1/81", grantId, bus.txByte); end
    bus.reqValid = '0;
    doneFrame(); repeat (G) tick();
  endtask

  initial begin
    clk = 1'b0; rstN = 1'b0; errClr = 1'b0;
    bus.reqValid = '0; bus.reqData = '0; bus.reqLast = '0; bus.txDone = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_burst();
    test_lock_release();
    test_watchdog();
    test_done_timeout();
    test_errclr_coincident();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
